// File: rtl/seq_divider_pkg.sv
// ----------------------------------------------------------------------------
// seq_divider_pkg
// Shared types and constants for the sequential radix-2 restoring divider.
//   state_e    : controller states (IDLE, CALC, FIX, DONE)
//   cnt_width  : bit counter width needed to hold the value WIDTH
//   DIV0_QUOT  : quotient returned on divide by zero (all ones), sliced to
//                WIDTH by the user
// ----------------------------------------------------------------------------
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int MAX_WIDTH = 32;

    localparam logic [MAX_WIDTH-1:0] DIV0_QUOT = '1;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// ----------------------------------------------------------------------------
// seq_divider_step
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor on a WIDTH+1-bit chain and keep the
// difference when it is non-negative.
// Ports:
//   rem_i      : current partial remainder
//   shift_in_i : dividend bit shifted into the remainder LSB
//   divisor_i  : divisor magnitude
//   rem_o      : next partial remainder
//   q_bit_o    : quotient bit produced by this step
// ----------------------------------------------------------------------------
module seq_divider_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             shift_in_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem_i, shift_in_i};

    // A + ~B + 1 keeps the subtract on the carry chain.
    assign trial = shifted + ~{1'b0, divisor_i} + {{WIDTH{1'b0}}, 1'b1};

    // rem_i < divisor, so a non-negative difference always fits in WIDTH
    // bits and the top bit of trial is a clean sign.
    assign q_bit_o = ~trial[WIDTH];
    assign rem_o   = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Multi-cycle radix-2 restoring integer divider with start/done handshake,
// one quotient bit per cycle.
// Build option: define SEQ_DIVIDER_SIGNED_EN to honour signed_op (magnitude
// conversion at load and sign fix-up in FIX). Without it every operation is
// unsigned and FIX is a one-cycle pass-through, so latency is unchanged.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   start                 : request strobe, sampled only in IDLE
//   signed_op             : two's-complement operands, sampled with start
//   dividend, divisor     : operands, sampled with start
//   busy                  : operation in flight (includes the done cycle)
//   done                  : one-cycle result-valid pulse
//   quotient, remainder   : registered results, held until next result
//   div_by_zero           : registered flag, cleared by next accepted start
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring step per cycle, counter counts WIDTH down to 0
// FIX   | apply result signs and register outputs
// DONE  | done pulse, results valid
// ----------------------------------------------------------------------------
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] acc_q, acc_d;      // dividend in, quotient bits out
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    logic [WIDTH-1:0] load_a;
    logic [WIDTH-1:0] load_b;
    logic [WIDTH-1:0] fix_quot;
    logic [WIDTH-1:0] fix_rem;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;
    logic sign_a;
    logic sign_b;

    assign sign_a = signed_op & dividend[WIDTH-1];
    assign sign_b = signed_op & divisor[WIDTH-1];

    // The most negative value maps to itself, which is its correct unsigned
    // magnitude, so overflow needs no special handling.
    assign load_a   = sign_a ? (~dividend + ONE) : dividend;
    assign load_b   = sign_b ? (~divisor + ONE) : divisor;
    assign fix_quot = neg_quo_q ? (~acc_q + ONE) : acc_q;
    assign fix_rem  = neg_rem_q ? (~rem_q + ONE) : rem_q;
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign load_a   = dividend;
    assign load_b   = divisor;
    assign fix_quot = acc_q;
    assign fix_rem  = rem_q;
`endif

    seq_divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i      (rem_q),
        .shift_in_i (acc_q[WIDTH-1]),
        .divisor_i  (dvs_q),
        .rem_o      (step_rem),
        .q_bit_o    (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
        dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quot_d  = DIV0_QUOT[WIDTH-1:0];
                        remd_d  = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        acc_d   = load_a;
                        dvs_d   = load_b;
                        cnt_d   = CW'(WIDTH);
                        dbz_d   = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_quo_d = sign_a ^ sign_b;
                        neg_rem_d = sign_a;
`endif
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                acc_d = {acc_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q - CW'(1);
                // The last step is the one that takes the counter to 0.
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quot_d  = fix_quot;
                remd_d  = fix_rem;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            remd_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dbz_q   <= dbz_d;
        end
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`endif

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 16;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, truncating toward zero when signed.
    function automatic void model(input bit sop, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
        int sa;
        int sb;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (SIGNED_EN && sop) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            dz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    // Called at a negedge; start is therefore sampled at the next posedge
    // (edge 0). inject_k > 0 pulses a competing 50/5 start in that cycle.
    task automatic run_op(input bit sop, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_k, input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        bit           edz;
        model(sop, a, b, eq, er, edz);
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (b == '0) begin
            @(negedge clk);
            chk({tag, " busy c1"}, 32'(busy), 32'd1);
            chk({tag, " done c1"}, 32'(done), 32'd1);
            chk({tag, " quotient"}, 32'(quotient), 32'(eq));
            chk({tag, " remainder"}, 32'(remainder), 32'(er));
            chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
            @(negedge clk);
            chk({tag, " busy c2"}, 32'(busy), 32'd0);
            chk({tag, " done c2"}, 32'(done), 32'd0);
            chk({tag, " quotient hold"}, 32'(quotient), 32'(eq));
            chk({tag, " flag hold"}, 32'(div_by_zero), 32'd1);
        end else begin
            for (int k = 1; k <= W + 2; k++) begin
                @(negedge clk);
                chk($sformatf("%s busy c%0d", tag, k), 32'(busy), 32'd1);
                chk($sformatf("%s done c%0d", tag, k), 32'(done), 32'(k == W + 2));
                if (k == 1)
                    chk({tag, " flag cleared"}, 32'(div_by_zero), 32'd0);
                if (k == W + 2) begin
                    chk({tag, " quotient"}, 32'(quotient), 32'(eq));
                    chk({tag, " remainder"}, 32'(remainder), 32'(er));
                    chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
                end
                if (k == inject_k) begin
                    start     = 1'b1;
                    signed_op = 1'b0;
                    dividend  = W'(50);
                    divisor   = W'(5);
                end else if (k == inject_k + 1) begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
            chk({tag, " busy after"}, 32'(busy), 32'd0);
            chk({tag, " done after"}, 32'(done), 32'd0);
            chk({tag, " quotient hold"}, 32'(quotient), 32'(eq));
            chk({tag, " remainder hold"}, 32'(remainder), 32'(er));
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           rs;

        reset_n   = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #3;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset quotient", 32'(quotient), 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset flag", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_op(1'b0, 16'd100, 16'd7, 0, "u100/7");
        run_op(1'b0, 16'h1234, 16'h0000, 0, "dbz");
        run_op(1'b0, 16'd100, 16'd7, 0, "flagclr");
        run_op(1'b1, 16'hFFF9, 16'd2, 0, "s-7/2");
        run_op(1'b1, 16'd7, 16'hFFFE, 0, "s7/-2");
        run_op(1'b0, 16'hFFF9, 16'd2, 0, "uFFF9/2");
        run_op(1'b1, 16'h8000, 16'hFFFF, 0, "sovf");
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 0, "umax");
        run_op(1'b0, 16'h0003, 16'hFFFF, 0, "usmall");
        run_op(1'b0, 16'd100, 16'd7, 5, "busystart");
        run_op(1'b0, 16'd50, 16'd5, 0, "b2b50/5");

        // Abort in cycle 8 of a running operation.
        signed_op = 1'b0;
        dividend  = 16'd100;
        divisor   = 16'd7;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort quotient", 32'(quotient), 32'd0);
        chk("abort remainder", 32'(remainder), 32'd0);
        chk("abort flag", 32'(div_by_zero), 32'd0);
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (k == 1) reset_n = 1'b1;
            chk($sformatf("abort no done %0d", k), 32'(done), 32'd0);
        end
        run_op(1'b0, 16'd9, 16'd3, 0, "post9/3");

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            if ($urandom_range(0, 7) == 0)
                rb = '0;
            else if ($urandom_range(0, 1) == 1)
                rb = W'($urandom_range(1, 20));
            else
                rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            run_op(rs, ra, rb, 0, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle radix-2 restoring integer divider for the qlf_k6n10f flow, built on the same carry-chain subtract primitive that `$alu` maps to. It takes a dividend/divisor pair through a start/done handshake and produces one quotient bit per cycle. The block is a soft-logic companion to the adder mapping: it consumes `$sub` results instead of producing them. It serves datapaths that need division without a hard DSP divider.

## Interface

Parameters:
- `WIDTH`, 16: operand, quotient and remainder width; legal range 4–32.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request strobe; sampled only in IDLE.
- `signed_op`, input, 1: treat operands as two's complement; sampled with `start`.
- `dividend`, input, WIDTH: numerator; sampled with `start`.
- `divisor`, input, WIDTH: denominator; sampled with `start`.
- `busy`, output, 1: high from the cycle after `start` is accepted until `done` drops.
- `done`, output, 1: single-cycle pulse; results are valid.
- `quotient`, output, WIDTH: registered quotient.
- `remainder`, output, WIDTH: registered remainder.
- `div_by_zero`, output, 1: registered flag; valid with `done`.

## Operation

- **Reset values:** state IDLE; `busy`, `done` and `div_by_zero` are 0; `quotient` and `remainder` are 0; the bit counter is 0.
- **States:**
  - **IDLE → CALC** on `start` with nonzero divisor.
  - **IDLE → DONE** on `start` with divisor == 0.
  - **CALC → FIX** when the counter reaches 0.
  - **FIX → DONE** unconditionally.
  - **DONE → IDLE** unconditionally.
- **Load:**
  - Store the operand magnitudes: |x| when signed, raw otherwise.
  - Store the sign of the quotient (dividend sign XOR divisor sign) and the sign of the remainder (dividend sign).
  - Set the counter to WIDTH.
- **CALC step:**
  - Shift the {partial remainder, dividend} pair left by 1.
  - Compute trial = partial remainder − divisor on a WIDTH+1-bit carry chain.
  - If trial is non-negative, keep trial and shift in a quotient bit of 1. Otherwise keep the old value and shift in 0.
  - Decrement the counter.
- **FIX:** apply two's-complement negation to the quotient and/or remainder according to the stored signs, then register them to the outputs.
- **Signed semantics:**
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - The quotient of the most negative value divided by −1 wraps to the most negative value, with remainder 0 and no flag.
- **Divide by zero:** `quotient` is all ones, `remainder` equals `dividend` unmodified, and `div_by_zero` = 1.
- **Start while busy** is ignored, with no queuing.
- **Result hold:** outputs hold until the next accepted `start`. `div_by_zero` is cleared on the next accepted `start`.

## Timing

- `start` is sampled at edge 0.
- **Normal case:**
  - `busy` is high during cycles 1..WIDTH+2.
  - `done` is high for exactly one cycle, cycle WIDTH+2.
  - Results become valid in the same cycle as `done` and remain stable afterwards.
- **Divide by zero:** `busy` and `done` are both high in cycle 1 only.
- **Back-to-back:** a new `start` is accepted at the first edge after `done` falls (IDLE). Minimum issue interval is WIDTH+3 cycles.
- **Reset:** `reset_n` low at any time, including mid-CALC, aborts immediately and asynchronously to the reset values. No `done` pulse is produced for the aborted operation.

## Configuration

- **Macro:** `SEQ_DIVIDER_SIGNED_EN`.
- **Defined:**
  - `signed_op` is honoured.
  - The magnitude conversion at load and the FIX-stage negation are built.
- **Undefined:**
  - `signed_op` is ignored and all operations are unsigned.
  - FIX still exists as a one-cycle pass-through, so latency is identical in both builds.

## Structure

- **Package `seq_divider_pkg`:**
  - FSM state enum: IDLE, CALC, FIX, DONE.
  - Counter width function: $clog2(WIDTH+1).
  - Localparam for the divide-by-zero quotient value (all ones).
- **Sub-module `seq_divider_step`:**
  - Combinational WIDTH+1-bit subtract-and-select.
  - Written as A + ~B + 1 so synthesis maps it onto the `adder_carry` chain.
  - Instantiated once.

## Test plan

Plan assumes WIDTH=16.

- **Unsigned:** 100 / 7, unsigned → q=14, r=2, `div_by_zero`=0. `done` pulses in cycle 18 only; `busy` is high in cycles 1–18.
- **Divide by zero:** 0x1234 / 0 → `done` in cycle 1, q=0xFFFF, r=0x1234, `div_by_zero`=1. The flag clears on the next accepted `start`.
- **Signed:** signed −7 / 2 → q=0xFFFD, r=0xFFFF. Signed 7 / −2 → q=0xFFFD, r=0x0001. Without the macro, 0xFFF9 / 2 → q=0x7FFC, r=1.
- **Signed overflow:** signed 0x8000 / 0xFFFF → q=0x8000, r=0, `div_by_zero`=0.
- **Start while busy:** pulse `start` with 50/5 at cycle 5 of a running 100/7 → it is ignored and the result is 14 r 2. Issuing 50/5 right after `done` gives 10 r 0 at WIDTH+2 cycles after its start.
- **Reset mid-operation:** drop `reset_n` in cycle 8 of a CALC → all outputs 0 immediately and no `done`. A following 9/3 gives 3 r 0 with normal latency.
